// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: fetch-to-decode instruction FIFO with flush
module fetch_instr_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic push, pop;
  assign in_ready = count != FULL;
  assign out_valid = count != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count <= FULL);
      assert (count[AW-1:0] == AW'(wr_ptr - rd_ptr));
    end
  end
endmodule
